// File: rtl/la_drtx_if.sv
// Word-side and rail-side signals of the dual-rail transmitter.
// The slave modport is the transmitter; master is the word source plus the link.
interface la_drtx_if #(
    parameter int DW = 2
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] tx_t;
    logic [DW-1:0] tx_f;
    logic          tx_ack;

    modport master (
        output in_valid, in_data, tx_ack,
        input  in_ready, tx_t, tx_f
    );

    modport slave (
        input  in_valid, in_data, tx_ack,
        output in_ready, tx_t, tx_f
    );
endinterface

// File: rtl/la_drtx.sv
// Dual-rail four-phase return-to-zero transmitter: one accepted word becomes one
// codeword on tx_t/tx_f, followed by a spacer, paced by the tx_ack wire.
module la_drtx #(
    parameter int DW      = 2,
    parameter int SYNC    = 2,
    parameter int TIMEOUT = 0,
    parameter     PROP    = "DEFAULT"
) (
    input  logic     clk,
    input  logic     rst,
    la_drtx_if.slave bus,
    output logic     busy,
    output logic     err
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RTZ  = 2'd2
    } state_t;

    state_t        state;
    logic          ack_s;
    logic          phase_done;
    logic [CW-1:0] phase_cnt;

    if (PROP != "DEFAULT") begin : g_prop_custom
        // No implementation-specific variants exist yet; the property only rides along.
    end

    if (SYNC == 0) begin : g_nosync
        assign ack_s = bus.tx_ack;
    end else begin : g_sync
        logic [SYNC-1:0] sync_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= SYNC'({sync_q, bus.tx_ack});
            end
        end

        assign ack_s = sync_q[SYNC-1];
    end

    // A stale high acknowledge left over in IDLE must block the next word.
    assign bus.in_ready = (state == IDLE) && !ack_s && !rst;
    assign busy         = (state != IDLE);

    // NOTE: always_comb gives every output a default first so no latch is inferred.
    always_comb begin
        phase_done = 1'b0;
        unique case (state)
            IDLE:    phase_done = bus.in_valid && bus.in_ready;
            DATA:    phase_done = ack_s;
            RTZ:     phase_done = !ack_s;
            default: phase_done = 1'b1;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus.tx_t <= '0;
            bus.tx_f <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (phase_done) begin
                        bus.tx_t <= bus.in_data;
                        bus.tx_f <= ~bus.in_data;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (phase_done) begin
                        bus.tx_t <= '0;
                        bus.tx_f <= '0;
                        state    <= RTZ;
                    end
                end
                RTZ: begin
                    if (phase_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.tx_t <= '0;
                    bus.tx_f <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Phase watchdog: counts cycles spent waiting on the receiver; the FSM never aborts.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt <= '0;
            err       <= 1'b0;
        end else if (phase_done) begin
            phase_cnt <= '0;
        end else if ((state != IDLE) && (phase_cnt != TMAX)) begin
            phase_cnt <= phase_cnt + CW'(1);
            if ((TIMEOUT > 0) && ((phase_cnt + CW'(1)) == TMAX)) begin
                err <= 1'b1;
            end
        end
    end
endmodule
